// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker for the traffic-light controller output. It samples the
// pedestrian request and the five lamp drives on every rising clock edge,
// decodes them into a crossing phase and flags the first protocol violation.
// It also counts completed crossings (WALK entries). The block only observes
// the controller and never drives it.
//
// Ports
//   clock            in   system clock, rising edge active
//   reset            in   synchronous active-low reset
//   start            in   pedestrian request (same signal the controller sees)
//   lightseq[4:0]    in   {car_red, car_amber, car_green, ped_stop, ped_walk}
//   phase[2:0]       out  decoded phase of the last sample
//                         0 IDLE 1 AMBER 2 RED 3 WALK 4 FLASH_ON 5 FLASH_OFF 7 BAD
//   request_pending  out  request seen, crossing not yet begun
//   error            out  sticky violation flag
//   error_code[2:0]  out  first violation: 0 none, 1 illegal pattern,
//                         2 illegal transition, 3 unrequested crossing,
//                         4 walk too short, 5 request timeout
//   crossings[7:0]   out  WALK entry count, wraps 255 -> 0
//
// Phase tracking (phase_q doubles as the "previous phase" register)
//   state      | meaning
//   IDLE       | cars green, pedestrians stopped
//   AMBER      | cars amber, crossing has begun
//   RED        | cars red, pedestrians still stopped
//   WALK       | cars red, pedestrians may walk
//   FLASH_ON   | cars amber, walk lamp on (flashing phase)
//   FLASH_OFF  | all lamps dark (flashing phase)
//   BAD        | lamp pattern not recognised; next legal pattern resyncs
// ---------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int unsigned MIN_WALK = 3,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] lightseq,
  output logic [2:0] phase,
  output logic       request_pending,
  output logic       error,
  output logic [2:0] error_code,
  output logic [7:0] crossings
);

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_AMBER     = 3'd1,
    PH_RED       = 3'd2,
    PH_WALK      = 3'd3,
    PH_FLASH_ON  = 3'd4,
    PH_FLASH_OFF = 3'd5,
    PH_BAD       = 3'd7
  } phase_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PATTERN = 3'd1;
  localparam logic [2:0] ERR_TRANS   = 3'd2;
  localparam logic [2:0] ERR_UNREQ   = 3'd3;
  localparam logic [2:0] ERR_SHORT   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  localparam logic [7:0] MIN_WALK_C   = 8'(MIN_WALK);
  localparam logic [7:0] WAIT_LAST_C  = 8'(MAX_WAIT - 1);
  localparam logic [7:0] CNT_MAX      = 8'hFF;

  phase_e     phase_q, phase_d;
  logic       pending_q, pending_d;
  logic       error_q, error_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cross_q, cross_d;
  logic [7:0] walk_cnt_q, walk_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  phase_e     ph_new;
  logic       ph_change;
  logic       leaving_walk;
  logic       wait_cond;
  logic       viol_pattern, viol_trans, viol_unreq, viol_short, viol_timeout;

  function automatic logic trans_ok(input phase_e p, input phase_e n);
    logic ok;
    ok = 1'b0;
    if (n == p) begin
      ok = 1'b1;
    end else begin
      case (p)
        PH_IDLE:      ok = (n == PH_AMBER);
        PH_AMBER:     ok = (n == PH_RED);
        PH_RED:       ok = (n == PH_WALK);
        PH_WALK:      ok = (n == PH_FLASH_ON);
        PH_FLASH_ON:  ok = (n == PH_FLASH_OFF) || (n == PH_IDLE);
        PH_FLASH_OFF: ok = (n == PH_FLASH_ON) || (n == PH_IDLE);
        default:      ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  // Pattern decode
  always_comb begin
    ph_new = PH_BAD;
    case (lightseq)
      5'b00110: ph_new = PH_IDLE;
      5'b01010: ph_new = PH_AMBER;
      5'b10010: ph_new = PH_RED;
      5'b10001: ph_new = PH_WALK;
      5'b01001: ph_new = PH_FLASH_ON;
      5'b00000: ph_new = PH_FLASH_OFF;
      default:  ph_new = PH_BAD;
    endcase
  end

  always_comb begin
    phase_d      = ph_new;
    pending_d    = pending_q;
    error_d      = error_q;
    code_d       = code_q;
    cross_d      = cross_q;
    walk_cnt_d   = walk_cnt_q;
    wait_cnt_d   = 8'd0;

    ph_change    = (ph_new != phase_q);
    leaving_walk = (phase_q == PH_WALK) && (ph_new != PH_WALK);

    viol_pattern = (ph_new == PH_BAD);
    // Coming out of BAD, any legal pattern is accepted to resync.
    viol_trans   = !viol_pattern && (phase_q != PH_BAD) && !trans_ok(phase_q, ph_new);
    viol_unreq   = (phase_q == PH_IDLE) && (ph_new == PH_AMBER) && !pending_q && !start;
    viol_short   = leaving_walk && (walk_cnt_q < MIN_WALK_C);

    // A waiting sample is one decoded as IDLE while a request was already
    // pending before it. The counter passes MAX_WAIT only once (it saturates
    // far above), so the timeout fires a single time per wait.
    wait_cond    = (ph_new == PH_IDLE) && pending_q;
    viol_timeout = wait_cond && (wait_cnt_q == WAIT_LAST_C);
    if (wait_cond) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : wait_cnt_q + 8'd1;
    end

    // A start arriving on the AMBER-entry edge belongs to this crossing.
    if (start) begin
      pending_d = 1'b1;
    end
    if ((ph_new == PH_AMBER) && ph_change) begin
      pending_d = 1'b0;
    end

    // Walk dwell counts WALK samples including the entry sample.
    if (ph_new == PH_WALK) begin
      if (ph_change) begin
        walk_cnt_d = 8'd1;
        cross_d    = cross_q + 8'd1;
      end else if (walk_cnt_q != CNT_MAX) begin
        walk_cnt_d = walk_cnt_q + 8'd1;
      end
    end

    if (!error_q) begin
      if (viol_pattern) begin
        error_d = 1'b1;
        code_d  = ERR_PATTERN;
      end else if (viol_trans) begin
        error_d = 1'b1;
        code_d  = ERR_TRANS;
      end else if (viol_unreq) begin
        error_d = 1'b1;
        code_d  = ERR_UNREQ;
      end else if (viol_short) begin
        error_d = 1'b1;
        code_d  = ERR_SHORT;
      end else if (viol_timeout) begin
        error_d = 1'b1;
        code_d  = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q    <= PH_IDLE;
      pending_q  <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
      cross_q    <= 8'd0;
      walk_cnt_q <= 8'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      error_q    <= error_d;
      code_q     <= code_d;
      cross_q    <= cross_d;
      walk_cnt_q <= walk_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign phase           = phase_q;
  assign request_pending = pending_q;
  assign error           = error_q;
  assign error_code      = code_q;
  assign crossings       = cross_q;

endmodule
